mp_add_seq: RTL and testbench

Multi-precision adder sequencer. Adds two N*K-bit signed operands plus carry-in by reusing one N-bit `n_adder` instance for K passes, one word per cycle, least-significant word first. It has a valid/ready handshake on both input and output. It sits between a requesting datapath and the shared N-bit adder, trading latency for area on wide additions.

---
 rtl/mp_add_pkg.sv | 17 +
 rtl/n_adder.sv | 17 +
 rtl/mp_add_seq.sv | 120 ++++++++++++
 tb/tb_mp_add_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared types for the multi-precision adder sequencer.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word counter width; a single-word operand still needs a 1-bit counter.
  function automatic int cnt_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/n_adder.sv
// Shared N-bit ripple word adder with carry-in and carry-out.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (N-bit words), ci (carry in) -> s (N-bit word sum), co (carry out).
module n_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder: W=N*K-bit a+b+ci using one N-bit adder, one word per cycle, LSW first.
// Latency: handshake in cycle 0, word i added in cycle i+1, out_valid from cycle K+1; one result per K+2 cycles.
// Backpressure: result held in DONE until out_ready; no new request is accepted until back in IDLE.
// Ports: clk/rstn; in_valid/in_ready with a, b, ci; out_valid/out_ready with sum, co, ovf; busy in RUN or DONE.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           ci,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] sum,
  output logic           co,
  output logic           ovf,
  output logic           busy
);

  localparam int              W    = N * K;
  localparam int              CW   = cnt_width(K);
  localparam logic [CW-1:0]   LAST = CW'(K - 1);

  state_t          state, state_nx;
  logic [W-1:0]    a_q, b_q;
  logic [CW-1:0]   cnt;
  logic            carry_q;

  logic [N-1:0]    a_w, b_w, s_w;
  logic            c_w;
  logic            last;

  // Current word of each captured operand, selected by the word counter.
  assign a_w  = a_q[int'(cnt) * N +: N];
  assign b_w  = b_q[int'(cnt) * N +: N];
  assign last = (cnt == LAST);

  n_adder #(.N(N)) u_word_add (
    .a  (a_w),
    .b  (b_w),
    .ci (carry_q),
    .s  (s_w),
    .co (c_w)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            cnt     <= '0;
            carry_q <= ci;
          end
        end
        RUN: begin
          sum[int'(cnt) * N +: N] <= s_w;
          carry_q                 <= c_w;
          if (last) begin
            // Park the counter in range so the word selects never index past W.
            cnt <= '0;
            co  <= c_w;
            // Signed overflow: like-signed operands giving a result of the other sign.
            ovf <= (a_w[N-1] == b_w[N-1]) && (s_w[N-1] != a_w[N-1]);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
module tb_mp_add_seq;

  localparam int N = 8;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_sum;
  logic         exp_co;
  logic         exp_ovf;

  mp_add_seq #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: true-width integer arithmetic. Unsigned W+1 bit sum for {co,sum};
  // signed overflow when the mathematical signed sum is not representable in W bits.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci);
    logic [W:0] u;
    longint     s;
    u       = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tci};
    exp_sum = u[W-1:0];
    exp_co  = u[W];
    s       = longint'($signed(ta)) + longint'($signed(tb)) + longint'(tci);
    exp_ovf = (s != longint'($signed(exp_sum)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for acceptance, then scramble the inputs.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci);
    int cyc;
    model(ta, tb, tci);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    ci       = tci;
    cyc      = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    ci       = 1'($urandom);
    chk("run_in_ready", 64'(in_ready), 64'd0);
    chk("run_busy", 64'(busy), 64'd1);
  endtask

  // Count cycles after the handshake until out_valid; expect cycle K+1.
  task automatic wait_done();
    int cyc;
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(K + 1));
  endtask

  task automatic check_res(input string tag);
    chk({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    chk({tag, "_co"}, 64'(co), 64'(exp_co));
    chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
  endtask

  // Hold the result for gap cycles, then consume it.
  task automatic consume(input int gap);
    out_ready = 1'b0;
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_sum", 64'(sum), 64'(exp_sum));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
    chk("post_sum_kept", 64'(sum), 64'(exp_sum));
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic [W-1:0] ra, rb;
    logic         rci;
    bit           spurious;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    ci        = 1'b0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Carry ripples through every word.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done();
    check_res("carry_chain");
    chk("carry_chain_const", 64'({co, ovf, sum}), 64'h2_0000_0000);
    consume(0);

    // Positive signed overflow.
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done();
    check_res("pos_ovf");
    chk("pos_ovf_const", 64'({co, ovf, sum}), 64'h1_8000_0000);
    consume(1);

    // Carry-in into word 0.
    send(32'h1234_5678, 32'h1111_1111, 1'b1);
    wait_done();
    check_res("carry_in");
    chk("carry_in_const", 64'({co, ovf, sum}), 64'h0_2345_678A);
    consume(0);

    // Backpressure with a new request waiting.
    send(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done();
    check_res("bp_first");
    held_sum = exp_sum;
    in_valid = 1'b1;
    a        = 32'hCAFE_0001;
    b        = 32'h0BAD_F00D;
    ci       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_sum", 64'(sum), 64'(held_sum));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_sum", 64'(sum), 64'(held_sum));
    send(32'hCAFE_0001, 32'h0BAD_F00D, 1'b0);
    wait_done();
    check_res("bp_second");
    consume(0);

    // Reset in the middle of RUN discards the pending result.
    send(32'h0F0F_0F0F, 32'h1010_1010, 1'b1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum", 64'(sum), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || !in_ready) spurious = 1'b1;
    end
    chk("mid_rst_no_result", 64'(spurious), 64'd0);

    // Random traffic with random idle and backpressure gaps.
    for (int t = 0; t < 200; t++) begin
      ra  = $urandom;
      rb  = $urandom;
      rci = 1'($urandom);
      case ($urandom_range(0, 3))
        0: ra = {1'b0, ra[W-2:0]};
        1: rb = ~ra;
        default: ;
      endcase
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      send(ra, rb, rci);
      wait_done();
      check_res("rand");
      consume($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
